// File: rtl/jtframe_i2s_sched_pkg.sv
// Shared definitions for the I2S sample scheduler.
// - state_e   : scheduler states (IDLE/PRIME/RUN)
// - URUN_W    : width of the saturating underrun counter
// - calc_step : accumulator increment per clk (half-bit rate in Hz)
package jtframe_i2s_sched_pkg;

  localparam int unsigned URUN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Half-bit rate: two channels * dw bits * two half-bits per bit, per frame.
  function automatic logic [31:0] calc_step(input int unsigned freq, input int unsigned dw);
    return 32'(freq * 4 * dw);
  endfunction

endpackage

// File: rtl/jtframe_i2s_fifo.sv
// Synchronous FIFO holding packed stereo pairs.
// Ports: clk/rst (async, active-high), push_i/wdata_i (write, ignored when
// full), pop_i (read, ignored when empty), rdata_o (head word, valid when
// not empty), full_o/empty_o/level_o (state registered at last edge).
module jtframe_i2s_fifo #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [AW:0]   wr_q, rd_q;
  logic          do_push, do_pop;

  assign level_o = wr_q - rd_q;
  // Occupancy never exceeds 2**AW, so the top bit alone flags full.
  assign full_o  = level_o[AW];
  assign empty_o = (wr_q == rd_q);
  assign rdata_o = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/jtframe_i2s_sched.sv
// Sample scheduler / timing controller in front of an I2S serializer.
// Inputs : clk, reset (async, active-high), clk_rate (Hz), enable,
//          snd_left/snd_right/snd_valid (sample pair offer).
// Outputs: snd_ready (!full), half_ce (half-bit enable), ld (frame start),
//          left_out/right_out (current pair), running (RUN state),
//          underrun_cnt (saturating), fifo_level (occupancy).
module jtframe_i2s_sched
  import jtframe_i2s_sched_pkg::*;
#(
  parameter int unsigned AUDIO_DW = 16,
  parameter int unsigned I2S_FREQ = 48_000,
  parameter int unsigned FIFO_AW  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         clk_rate,
  input  logic                enable,
  input  logic [AUDIO_DW-1:0] snd_left,
  input  logic [AUDIO_DW-1:0] snd_right,
  input  logic                snd_valid,
  output logic                snd_ready,
  output logic                half_ce,
  output logic                ld,
  output logic [AUDIO_DW-1:0] left_out,
  output logic [AUDIO_DW-1:0] right_out,
  output logic                running,
  output logic [URUN_W-1:0]   underrun_cnt,
  output logic [FIFO_AW:0]    fifo_level
);

  localparam logic [31:0]       STEP      = calc_step(I2S_FREQ, AUDIO_DW);
  localparam int unsigned       PH_W      = $clog2(4 * AUDIO_DW);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(4 * AUDIO_DW - 1);
  localparam logic [FIFO_AW:0]  LVL_START = (FIFO_AW + 1)'(2 ** (FIFO_AW - 1));

  state_e                state_q, state_d;
  logic                  stop_q, stop_d;
  logic [31:0]           acc_q, acc_d;
  logic [PH_W-1:0]       ph_q, ph_d;
  logic                  half_ce_q, ld_q, running_q, pop_q;
  logic [AUDIO_DW-1:0]   left_q, right_q;
  logic [URUN_W-1:0]     urun_q;

  logic [32:0]           nxt;
  logic                  fire, boundary, ld_d;
  logic [2*AUDIO_DW-1:0] fifo_rdata;
  logic                  fifo_full, fifo_empty;

  jtframe_i2s_fifo #(
    .DW (2 * AUDIO_DW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (snd_valid),
    .wdata_i ({snd_left, snd_right}),
    .pop_i   (pop_q),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    nxt      = {1'b0, acc_q} + {1'b0, STEP};
    boundary = half_ce_q && (ph_q == PH_LAST);
    state_d  = state_q;
    stop_d   = stop_q;
    case (state_q)
      IDLE:  if (enable) state_d = PRIME;
      PRIME: begin
        if (!enable) state_d = IDLE;
        else if (boundary && fifo_level >= LVL_START) state_d = RUN;
      end
      RUN: begin
        // A disable request is latched so the frame in progress completes.
        if (!enable) stop_d = 1'b1;
        if (boundary && (stop_q || !enable)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != RUN) stop_d = 1'b0;

    fire  = 1'b0;
    acc_d = '0;
    ph_d  = '0;
    if (state_q != IDLE && state_d != IDLE) begin
      if (half_ce_q) ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
      else           ph_d = ph_q;
      // With clk_rate <= STEP every cycle fires; keep acc at 0 so it cannot creep.
      if (clk_rate <= STEP) begin
        fire = 1'b1;
      end else if (nxt >= {1'b0, clk_rate}) begin
        fire  = 1'b1;
        acc_d = 32'(nxt - {1'b0, clk_rate});
      end else begin
        acc_d = nxt[31:0];
      end
    end
    // half_ce/ld are registered, so decide on the pulse whose phase will be 0.
    ld_d = fire && (ph_d == '0) && (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      stop_q    <= 1'b0;
      acc_q     <= '0;
      ph_q      <= '0;
      half_ce_q <= 1'b0;
      ld_q      <= 1'b0;
      running_q <= 1'b0;
      pop_q     <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      urun_q    <= '0;
    end else begin
      state_q   <= state_d;
      stop_q    <= stop_d;
      acc_q     <= acc_d;
      ph_q      <= ph_d;
      half_ce_q <= fire;
      ld_q      <= ld_d;
      running_q <= (state_d == RUN);
      // Outputs take the head word with ld; the pointer advances one cycle
      // later, so a full FIFO stays full (snd_ready low) during the ld cycle.
      pop_q     <= ld_d && !fifo_empty;
      if (state_d == IDLE) begin
        left_q  <= '0;
        right_q <= '0;
      end else if (ld_d) begin
        if (!fifo_empty) begin
          {left_q, right_q} <= fifo_rdata;
        end else if (urun_q != '1) begin
          urun_q <= urun_q + 1'b1;
        end
      end
    end
  end

  assign snd_ready    = !fifo_full;
  assign half_ce      = half_ce_q;
  assign ld           = ld_q;
  assign running      = running_q;
  assign left_out     = left_q;
  assign right_out    = right_q;
  assign underrun_cnt = urun_q;

endmodule

// File: tb/tb_jtframe_i2s_sched.sv
// Self-checking bench for jtframe_i2s_sched (AUDIO_DW=16, 48 kHz, 6.144 MHz).
module tb_jtframe_i2s_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] clk_rate = 32'd6_144_000;
  logic        enable = 1'b0;
  logic [15:0] snd_left = '0, snd_right = '0;
  logic        snd_valid = 1'b0;
  logic        snd_ready, half_ce, ld, running;
  logic [15:0] left_out, right_out;
  logic [7:0]  underrun_cnt;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_ld = 0;

  jtframe_i2s_sched #(
    .AUDIO_DW (16),
    .I2S_FREQ (48_000),
    .FIFO_AW  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_rate     (clk_rate),
    .enable       (enable),
    .snd_left     (snd_left),
    .snd_right    (snd_right),
    .snd_valid    (snd_valid),
    .snd_ready    (snd_ready),
    .half_ce      (half_ce),
    .ld           (ld),
    .left_out     (left_out),
    .right_out    (right_out),
    .running      (running),
    .underrun_cnt (underrun_cnt),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        push;
    logic [15:0] pl, pr;
    logic [15:0] el, er;
    logic [7:0]  eu;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    int k = 0;
    snd_left = l; snd_right = r; snd_valid = 1'b1;
    while (!snd_ready && k < 300) begin tick(); k++; end
    check("push_ready", snd_ready, 1);
    tick();
    snd_valid = 1'b0;
  endtask

  task automatic wait_ld(output int gap, output bit ok);
    int k = 0;
    do begin tick(); k++; end while (!ld && k < 300);
    ok = ld;
    check("ld_seen", ld, 1);
    gap = cyc - last_ld;
    last_ld = cyc;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, snd_ready, 1);
    check({tag, "_half_ce"}, half_ce, 0);
    check({tag, "_ld"}, ld, 0);
    check({tag, "_left"}, left_out, 0);
    check({tag, "_right"}, right_out, 0);
    check({tag, "_running"}, running, 0);
    check({tag, "_urun"}, underrun_cnt, 0);
    check({tag, "_level"}, fifo_level, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; snd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int gap;
    bit ok;
    int first_run, first_ld;

    tbl[0] = '{1'b0, 16'h0000, 16'h0000, 16'h0001, 16'hFFFF, 8'd0};
    tbl[1] = '{1'b0, 16'h0000, 16'h0000, 16'h0001, 16'hFFFF, 8'd1};
    tbl[2] = '{1'b1, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 8'd1};
    tbl[3] = '{1'b0, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 8'd2};
    tbl[4] = '{1'b1, 16'h00AA, 16'h5500, 16'h00AA, 16'h5500, 8'd2};
    tbl[5] = '{1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 8'd2};

    // Reset values
    do_reset();
    check_reset_vals("rst");

    // Cadence and data order: prefill two pairs, then enable
    push(16'h1234, 16'hABCD);
    push(16'h0001, 16'hFFFF);
    check("prefill_level", fifo_level, 2);
    enable = 1'b1;
    for (int n = 1; n <= 131; n++) begin
      tick();
      check("cad_half_ce", half_ce, (n >= 3 && n % 2 == 1) ? 1 : 0);
      check("cad_ld", ld, (n == 131) ? 1 : 0);
      check("cad_running", running, (n >= 130) ? 1 : 0);
    end
    last_ld = cyc;
    check("ld1_left", left_out, 16'h1234);
    check("ld1_right", right_out, 16'hABCD);
    check("ld1_urun", underrun_cnt, 0);
    tick();
    check("ld1_level_after_pop", fifo_level, 1);

    // Table: optional push within the frame, then compare at the next ld
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].push) push(tbl[i].pl, tbl[i].pr);
      wait_ld(gap, ok);
      if (!ok) break;
      check("tbl_gap", gap, 128);
      check("tbl_left", left_out, tbl[i].el);
      check("tbl_right", right_out, tbl[i].er);
      check("tbl_urun", underrun_cnt, tbl[i].eu);
    end

    // Underrun saturation: 300 more starved frames
    for (int i = 0; i < 300; i++) begin
      wait_ld(gap, ok);
      if (!ok) break;
    end
    check("sat_urun", underrun_cnt, 255);
    check("sat_left", left_out, 16'hFFFF);
    check("sat_right", right_out, 16'h0000);

    // Disable at ph=10: frame completes, running drops after the boundary
    for (int o = 1; o <= 200; o++) begin
      tick();
      if (o == 20) begin
        check("dis_ph10_half_ce", half_ce, 1);
        enable = 1'b0;
      end
      check("dis_ld", ld, 0);
      if (o == 126) begin
        check("dis_boundary_half_ce", half_ce, 1);
        check("dis_running_126", running, 1);
      end
      if (o == 127) begin
        check("dis_running_127", running, 0);
        check("dis_left_idle", left_out, 0);
      end
      if (o >= 127) check("dis_half_ce_idle", half_ce, 0);
    end

    // Priming: RUN only at the first boundary with level >= 2
    do_reset();
    enable = 1'b1;
    first_run = 0;
    first_ld = 0;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (n == 140) begin snd_left = 16'h0F0F; snd_right = 16'hF0F0; snd_valid = 1'b1; end
      if (n == 141) snd_valid = 1'b0;
      if (n == 300) begin snd_left = 16'h1357; snd_right = 16'h2468; snd_valid = 1'b1; end
      if (n == 301) snd_valid = 1'b0;
      if (running && first_run == 0) first_run = n;
      if (ld && first_ld == 0) begin
        first_ld = n;
        check("prime_left", left_out, 16'h0F0F);
        check("prime_right", right_out, 16'hF0F0);
        check("prime_urun", underrun_cnt, 0);
      end
    end
    check("prime_first_run", first_run, 386);
    check("prime_first_ld", first_ld, 387);

    // Full FIFO with snd_valid held across the ld pop
    do_reset();
    push(16'h1111, 16'h2222);
    push(16'h3333, 16'h4444);
    push(16'h5A5A, 16'hA5A5);
    push(16'h7777, 16'h8888);
    check("full_level", fifo_level, 4);
    check("full_ready", snd_ready, 0);
    snd_left = 16'h5555; snd_right = 16'h6666; snd_valid = 1'b1;
    enable = 1'b1;
    wait_ld(gap, ok);
    check("fp_ready_at_ld", snd_ready, 0);
    check("fp_left_a", left_out, 16'h1111);
    check("fp_right_a", right_out, 16'h2222);
    tick();
    check("fp_ready_after", snd_ready, 1);
    check("fp_level_after_pop", fifo_level, 3);
    tick();
    snd_valid = 1'b0;
    check("fp_level_refill", fifo_level, 4);
    begin
      logic [15:0] el[5];
      logic [15:0] er[5];
      el = '{16'h3333, 16'h5A5A, 16'h7777, 16'h5555, 16'h5555};
      er = '{16'h4444, 16'hA5A5, 16'h8888, 16'h6666, 16'h6666};
      for (int i = 0; i < 5; i++) begin
        wait_ld(gap, ok);
        if (!ok) break;
        check("fp_left", left_out, el[i]);
        check("fp_right", right_out, er[i]);
        check("fp_urun", underrun_cnt, (i == 4) ? 1 : 0);
      end
    end

    // Asynchronous reset mid-frame
    repeat (37) tick();
    check("pre_rst_running", running, 1);
    reset = 1'b1;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b0;
    tick();
    check("post_rst_running", running, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtframe_i2s_sched.md
# jtframe_i2s_sched

Sample scheduler and timing controller that sits between a core's sound output and an I2S serializer. It accepts stereo samples over a valid/ready handshake and buffers them in a small FIFO. It derives the serializer's half-bit clock enable from the system clock rate using a fractional accumulator. At each frame boundary it hands exactly one stereo pair to the serializer, and it repeats the last pair and counts the event when the core underruns.

## Interface
Parameters:
- `AUDIO_DW`, 16: sample width per channel, 8..32.
- `I2S_FREQ`, 48_000: frame (LR) rate in Hz.
- `FIFO_AW`, 2: FIFO address width. Depth is 2**FIFO_AW entries.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `clk_rate` in 32: `clk` frequency in Hz. Quasi-static.
- `enable` in 1: run request.
- `snd_left` in AUDIO_DW: left sample, two's complement.
- `snd_right` in AUDIO_DW: right sample, two's complement.
- `snd_valid` in 1: sample pair offered.
- `snd_ready` out 1: FIFO can accept. Equals !full.
- `half_ce` out 1: one-cycle pulse per serializer half-bit period.
- `ld` out 1: one-cycle frame-start pulse, coincident with a `half_ce`.
- `left_out` out AUDIO_DW: pair for the current frame. Stable between `ld` pulses.
- `right_out` out AUDIO_DW: see `left_out`.
- `running` out 1: high in the RUN state.
- `underrun_cnt` out 8: saturating count of underrun frames.
- `fifo_level` out FIFO_AW+1: current occupancy.

## Operation
- **Accumulator.**
  - STEP = I2S_FREQ*4*AUDIO_DW, held as a 32-bit constant.
  - Each `clk`, nxt = acc + STEP.
  - If nxt >= `clk_rate`: acc <= nxt − `clk_rate` and `half_ce` is 1 for that cycle. Otherwise acc <= nxt.
  - If `clk_rate` <= STEP, `half_ce` fires every cycle. This is legal, and there is no error flag.
- **Phase counter.**
  - `ph` counts from 0 to 4*AUDIO_DW−1, advancing on `half_ce` and wrapping.
  - Frame boundary = `half_ce` while `ph` = 4*AUDIO_DW−1. `ld` is driven on the following `half_ce`, when `ph` = 0.
- **FIFO.**
  - Write when `snd_valid` && `snd_ready`. Read only at `ld` in RUN.
  - When full, a same-cycle pop does not make room for a push: `snd_ready` stays low for that cycle.
- **State machine:** IDLE, PRIME, RUN.
  - IDLE:
    - `ph` and acc are held at 0 and `half_ce` is suppressed.
    - `left_out`/`right_out` are 0.
    - The FIFO still accepts writes.
    - Go to PRIME when `enable` = 1.
  - PRIME:
    - The accumulator and `ph` run, but `ld` is suppressed.
    - Go to RUN at a frame boundary when `fifo_level` >= 2**(FIFO_AW−1).
    - Go to IDLE immediately when `enable` = 0.
  - RUN:
    - On each `ld`: if the FIFO is not empty, pop into `left_out`/`right_out`.
    - If the FIFO is empty, hold the previous pair and increment `underrun_cnt`, saturating at 255.
    - If `enable` = 0 is seen, finish the current frame and go to IDLE at the frame boundary. The FIFO contents are kept.
- `underrun_cnt` is cleared only by `reset`.

## Timing
- **Reset values.**
  - All outputs 0, except `snd_ready` = 1.
  - acc = 0, `ph` = 0, FIFO empty, state IDLE.
  - Reset asserted mid-frame aborts immediately, with no completion of the frame.
- **Latency.**
  - A pair written while `fifo_level` = 0 in RUN is presented at the next `ld`.
  - That is at most 4*AUDIO_DW `half_ce` periods later.
  - `left_out`/`right_out` update in the same cycle `ld` is high.
- **Output registers.**
  - `half_ce`, `ld` and `running` are registered.
  - `snd_ready` and `fifo_level` reflect the FIFO state registered at the previous edge.
- **PRIME to RUN.**
  - The transition happens on the frame-boundary `half_ce`.
  - The first `ld` follows on the next `half_ce`.

## Structure
- Shared package holds:
  - the STEP computation helper;
  - the state encoding constants IDLE/PRIME/RUN;
  - the underrun counter width, which is 8.
- One sub-module, `jtframe_i2s_fifo`:
  - synchronous FIFO of 2*AUDIO_DW-bit words, depth 2**FIFO_AW;
  - full/empty/level outputs;
  - asynchronous reset.
- The accumulator, phase counter and FSM live in the top level.

## Test plan
All scenarios use AUDIO_DW=16, I2S_FREQ=48000 and `clk_rate`=6_144_000.
- **Cadence.** `enable`=1 with the FIFO pre-filled with 2 pairs → `half_ce` every 2 clocks, and `ld` every 128 clocks once in RUN.
- **Priming.** Write pairs one at a time, `enable`=1 → RUN is entered only at the first frame boundary with `fifo_level` >= 2. No `ld` occurs before that.
- **Data order.** Push (0x1234,0xABCD) then (0x0001,0xFFFF) → consecutive `ld` pulses present exactly these pairs in order.
- **Underrun.** Stop writing in RUN → the last pair repeats and `underrun_cnt` increments by 1 per `ld`. After 300 underrun frames it reads 255.
- **Full plus pop.** Fill 4 entries and hold `snd_valid` across an `ld` → `snd_ready` is 0 in the `ld` cycle and 1 on the next cycle. No data is lost or duplicated.
- **Disable and reset.** `enable` dropped at `ph`=10 → `ld` stops after the frame boundary, and `running`=0 one cycle after the boundary. A `reset` pulse mid-frame → all outputs return to their reset values asynchronously.
